// File: rtl/cla_pkg.sv
// ============================================================================
// Module   : cla_pkg
// Brief    : Shared defaults and the group propagate/generate pair type for
//            the pipelined carry-lookahead adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

   localparam int CLA_DEFAULT_WIDTH = 16;
   localparam int CLA_DEFAULT_GROUP = 4;

   typedef struct packed {
      logic p;
      logic g;
   } cla_pg_t;

endpackage : cla_pkg

`default_nettype wire

// File: rtl/cla_group.sv
// ============================================================================
// Module   : cla_group
// Brief    : One GROUP-bit lookahead slice: group P/G from per-bit p/g, and the
//            slice sum bits from p, g and the slice carry-in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_DEFAULT_GROUP
) (
   input  logic [GROUP-1:0] i_p,
   input  logic [GROUP-1:0] i_g,
   input  logic             i_cin,
   output cla_pg_t          o_pg,
   output logic [GROUP-1:0] o_sum
);

   logic [GROUP-1:0] w_c;
   logic             w_acc;
   logic             w_term;
   logic             w_gg;
   logic             w_gterm;

   // Each bit carry is a flat sum of products, so no carry ripples within the slice.
   always_comb begin
      w_c    = '0;
      w_acc  = 1'b0;
      w_term = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         w_acc = i_cin;
         for (int k = 0; k < i; k++) begin
            w_acc = w_acc & i_p[k];
         end
         for (int k = 0; k < i; k++) begin
            w_term = i_g[k];
            for (int m = k + 1; m < i; m++) begin
               w_term = w_term & i_p[m];
            end
            w_acc = w_acc | w_term;
         end
         w_c[i] = w_acc;
      end
   end

   always_comb begin
      w_gg    = 1'b0;
      w_gterm = 1'b0;
      for (int k = 0; k < GROUP; k++) begin
         w_gterm = i_g[k];
         for (int m = k + 1; m < GROUP; m++) begin
            w_gterm = w_gterm & i_p[m];
         end
         w_gg = w_gg | w_gterm;
      end
   end

   assign o_pg.p = &i_p;
   assign o_pg.g = w_gg;
   assign o_sum  = i_p ^ w_c;

endmodule : cla_group

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Two-stage valid/ready carry-lookahead adder/subtractor.
//            Optional signed-overflow output enabled by macro CLA_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_DEFAULT_WIDTH,
   parameter int GROUP = CLA_DEFAULT_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NGRP = WIDTH / GROUP;

   logic [WIDTH-1:0]          w_b_eff;
   logic [WIDTH-1:0]          w_p;
   logic [WIDTH-1:0]          w_g;
   logic                      w_cin_eff;
   cla_pg_t [NGRP-1:0]        w_s1_pg;
   logic [WIDTH-1:0]          w_s1_sum_unused;

   logic                      r_s1_valid;
   logic [WIDTH-1:0]          r_p;
   logic [WIDTH-1:0]          r_g;
   logic                      r_cin;
   cla_pg_t [NGRP-1:0]        r_pg;

   logic [NGRP:0]             w_gc;
   logic                      w_acc;
   logic                      w_term;
   logic [WIDTH-1:0]          w_sum;
   cla_pg_t [NGRP-1:0]        w_s2_pg_unused;

   logic                      w_s2_adv;
   logic                      w_s1_adv;

   logic                      r_out_valid;
   logic [WIDTH-1:0]          r_s;
   logic                      r_cout;

   assign w_s2_adv = !r_out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // Subtraction is A + ~B + 1; the external carry-in is overridden.
   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub | cin;
   assign w_p       = a ^ w_b_eff;
   assign w_g       = a & w_b_eff;

   for (genvar j = 0; j < NGRP; j++) begin : g_s1_grp
      cla_group #(
         .GROUP (GROUP)
      ) u_grp (
         .i_p   (w_p[j*GROUP +: GROUP]),
         .i_g   (w_g[j*GROUP +: GROUP]),
         .i_cin (1'b0),
         .o_pg  (w_s1_pg[j]),
         .o_sum (w_s1_sum_unused[j*GROUP +: GROUP])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_p        <= '0;
         r_g        <= '0;
         r_cin      <= 1'b0;
         r_pg       <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_p   <= w_p;
            r_g   <= w_g;
            r_cin <= w_cin_eff;
            r_pg  <= w_s1_pg;
         end
      end
   end

   // Group carries as flat sums of products over the registered group P/G.
   always_comb begin
      w_gc   = '0;
      w_acc  = 1'b0;
      w_term = 1'b0;
      for (int j = 0; j <= NGRP; j++) begin
         w_acc = r_cin;
         for (int k = 0; k < j; k++) begin
            w_acc = w_acc & r_pg[k].p;
         end
         for (int k = 0; k < j; k++) begin
            w_term = r_pg[k].g;
            for (int m = k + 1; m < j; m++) begin
               w_term = w_term & r_pg[m].p;
            end
            w_acc = w_acc | w_term;
         end
         w_gc[j] = w_acc;
      end
   end

   for (genvar j = 0; j < NGRP; j++) begin : g_s2_grp
      cla_group #(
         .GROUP (GROUP)
      ) u_grp (
         .i_p   (r_p[j*GROUP +: GROUP]),
         .i_g   (r_g[j*GROUP +: GROUP]),
         .i_cin (w_gc[j]),
         .o_pg  (w_s2_pg_unused[j]),
         .o_sum (w_sum[j*GROUP +: GROUP])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_s         <= '0;
         r_cout      <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s    <= w_sum;
            r_cout <= w_gc[NGRP];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign s         = r_s;
   assign cout      = r_cout;

`ifdef CLA_OVF_EN
   logic w_msb_carry;
   logic r_ovf;

   // Carry into the MSB recovered from its sum bit: s = p ^ c.
   assign w_msb_carry = w_sum[WIDTH-1] ^ r_p[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_s2_adv && r_s1_valid) begin
         r_ovf <= w_msb_carry ^ w_gc[NGRP];
      end
   end

   assign ovf = r_ovf;
`endif

endmodule : pipelined_cla_adder

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Brief    : Directed self-checking bench for pipelined_cla_adder (16/4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_cla_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        cout;
`ifdef CLA_OVF_EN
   logic        ovf;
`endif

   int errors = 0;
   int checks = 0;

   logic [15:0] st_a   [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                               16'h4444, 16'h5555, 16'h6666, 16'hF777};
   logic [15:0] st_exp [8] = '{16'h0F0F, 16'h2021, 16'h3131, 16'h4243,
                               16'h5353, 16'h6465, 16'h7575, 16'h0687};
   logic        st_co  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   pipelined_cla_adder #(
      .WIDTH (16),
      .GROUP (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout)
`ifdef CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts);
      in_valid = v;
      a        = ta;
      b        = tb_;
      cin      = tc;
      sub      = ts;
   endtask

   task automatic idle();
      drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo);
      drive(1'b1, ta, tb_, tc, ts);
      chk({tag, "_rdy"}, in_ready, 1);
      nxt();
      idle();
      chk({tag, "_lat1"}, out_valid, 0);
      nxt();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_s"}, s, es);
      chk({tag, "_cout"}, cout, ec);
`ifdef CLA_OVF_EN
      chk({tag, "_ovf"}, ovf, eo);
`endif
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      idle();
      repeat (2) nxt();
      chk("rst_valid", out_valid, 0);
      chk("rst_s", s, 0);
      chk("rst_cout", cout, 0);
`ifdef CLA_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      rst_n = 1'b1;
      #1;
      chk("rdy_after_rst", in_ready, 1);
      nxt();

      single("add",        16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      single("wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Back-to-back stream: result t appears two negedges after it is driven.
      for (int t = 0; t < 10; t++) begin
         if (t >= 2) begin
            chk($sformatf("stream%0d_valid", t - 2), out_valid, 1);
            chk($sformatf("stream%0d_s", t - 2), s, st_exp[t-2]);
            chk($sformatf("stream%0d_cout", t - 2), cout, st_co[t-2]);
         end
         if (t < 8) begin
            chk($sformatf("stream%0d_rdy", t), in_ready, 1);
            drive(1'b1, st_a[t], 16'h0F0F, t[0], 1'b0);
         end else begin
            idle();
         end
         nxt();
      end
      chk("stream_drained", out_valid, 0);

      // Backpressure: two beats accepted, third held off until out_ready returns.
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
      chk("stall_rdy0", in_ready, 1);
      nxt();
      chk("stall_rdy1", in_ready, 1);
      drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      nxt();
      drive(1'b1, 16'h0100, 16'h0100, 1'b0, 1'b0);
      for (int t = 2; t < 5; t++) begin
         chk($sformatf("stall%0d_rdy", t), in_ready, 0);
         chk($sformatf("stall%0d_valid", t), out_valid, 1);
         chk($sformatf("stall%0d_s", t), s, 16'h0003);
         nxt();
      end
      out_ready = 1'b1;
      #1;
      chk("stall_release_rdy", in_ready, 1);
      chk("stall_release_s", s, 16'h0003);
      nxt();
      chk("stall_y_valid", out_valid, 1);
      chk("stall_y_s", s, 16'h0100);
      idle();
      nxt();
      chk("stall_z_valid", out_valid, 1);
      chk("stall_z_s", s, 16'h0200);
      nxt();
      chk("stall_drained", out_valid, 0);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      drive(1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0);
      nxt();
      drive(1'b1, 16'h2222, 16'h2222, 1'b0, 1'b0);
      nxt();
      chk("inflight_valid", out_valid, 1);
      idle();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_s", s, 0);
      chk("midrst_cout", cout, 0);
      nxt();
      nxt();
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #1;
      chk("postrst_rdy", in_ready, 1);
      for (int t = 0; t < 3; t++) begin
         nxt();
         chk($sformatf("postrst%0d_valid", t), out_valid, 0);
      end
      single("post_rst", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pipelined_cla_adder

`default_nettype wire
